// File: rtl/avalon_mem_arbiter.sv
// Round-robin arbiter that shares one Avalon-MM RAM slave between an instruction
// fetch master (m0) and a data master (m1), granting one whole transaction at a time.
module avalon_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   output logic [1:0]          grant,
   output logic                err
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             last;
   logic [CNT_W-1:0] wd_cnt;
   logic             req0;
   logic             req1;
   logic             granted;
   logic             stall;

   assign req0    = m0_read | m0_write;
   assign req1    = m1_read | m1_write;
   assign granted = (state == GRANT0) || (state == GRANT1);
   assign stall   = granted && s_waitrequest;

   always_comb begin
      state_nxt      = state;
      s_address      = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = '0;
      s_byteenable   = '0;
      m0_waitrequest = 1'b1;
      m0_readdata    = '0;
      m1_waitrequest = 1'b1;
      m1_readdata    = '0;
      grant          = 2'b00;
      case (state)
         IDLE: begin
            if (req0 && req1)
               state_nxt = last ? GRANT0 : GRANT1;
            else if (req0)
               state_nxt = GRANT0;
            else if (req1)
               state_nxt = GRANT1;
         end
         GRANT0: begin
            s_address      = m0_address;
            s_read         = m0_read;
            s_write        = m0_write;
            s_writedata    = m0_writedata;
            s_byteenable   = m0_byteenable;
            m0_waitrequest = s_waitrequest;
            m0_readdata    = s_readdata;
            grant          = 2'b01;
            // A dropped request is treated like a completion: release the slave.
            if (!req0 || !s_waitrequest)
               state_nxt = IDLE;
         end
         GRANT1: begin
            s_address      = m1_address;
            s_read         = m1_read;
            s_write        = m1_write;
            s_writedata    = m1_writedata;
            s_byteenable   = m1_byteenable;
            m1_waitrequest = s_waitrequest;
            m1_readdata    = s_readdata;
            grant          = 2'b10;
            if (!req1 || !s_waitrequest)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         last   <= 1'b1;
         err    <= 1'b0;
         wd_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (granted && state_nxt == IDLE)
            last <= (state == GRANT1);
         // Watchdog counts consecutive stalled grant cycles and saturates.
         if (!granted || state_nxt == IDLE)
            wd_cnt <= '0;
         else if (stall && wd_cnt != CNT_MAX)
            wd_cnt <= wd_cnt + CNT_W'(1);
         if (TIMEOUT > 0 && stall && wd_cnt == CNT_LAST)
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench for avalon_mem_arbiter: a small RAM model behind the slave port,
// one task per scenario, each comparing against hand-computed values.
module tb_avalon_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_address, m1_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic [31:0] s_address;
   logic        s_read, s_write;
   logic [31:0] s_writedata;
   logic [3:0]  s_byteenable;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic [1:0]  grant;
   logic        err;

   logic [31:0] mem [0:63];

   int checks   = 0;
   int failures = 0;

   avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .grant(grant), .err(err)
   );

   always #5 clk = ~clk;

   // RAM model: reloaded whenever reset is high, byte-enabled writes otherwise.
   assign s_readdata = mem[s_address[7:2]];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[1] <= 32'h24020010;
         mem[2] <= 32'h11112222;
      end else if (s_write && !s_waitrequest) begin
         for (int b = 0; b < 4; b++)
            if (s_byteenable[b]) mem[s_address[7:2]][8*b +: 8] <= s_writedata[8*b +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 4'hF;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 4'hF;
      s_waitrequest = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rst_grant got=%b exp=00", grant); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
      checks++; if ({s_read, s_write} !== 2'b00) begin failures++; $display("FAIL rst_s_rw got=%b exp=00", {s_read, s_write}); end
      checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin failures++; $display("FAIL rst_wait got=%b exp=11", {m0_waitrequest, m1_waitrequest}); end
      checks++; if (m0_readdata !== 32'h0) begin failures++; $display("FAIL rst_m0_rdata got=%h exp=0", m0_readdata); end
      tick();
   endtask

   task automatic test_single_read();
      do_reset();
      m0_address = 32'h04; m0_read = 1'b1;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL sr_idle_grant got=%b exp=00", grant); end
      checks++; if (m0_waitrequest !== 1'b1) begin failures++; $display("FAIL sr_idle_wait got=%b exp=1", m0_waitrequest); end
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL sr_grant got=%b exp=01", grant); end
      checks++; if (s_read !== 1'b1 || s_address !== 32'h04) begin failures++; $display("FAIL sr_s_fwd got=%b/%h exp=1/00000004", s_read, s_address); end
      checks++; if (m0_readdata !== 32'h24020010) begin failures++; $display("FAIL sr_rdata got=%h exp=24020010", m0_readdata); end
      checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL sr_m0_wait got=%b exp=0", m0_waitrequest); end
      checks++; if (m1_waitrequest !== 1'b1) begin failures++; $display("FAIL sr_m1_wait got=%b exp=1", m1_waitrequest); end
      tick();
      m0_read = 1'b0;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL sr_done_grant got=%b exp=00", grant); end
      tick();
   endtask

   task automatic test_both_request();
      do_reset();
      m0_address = 32'h08; m0_read = 1'b1;
      m1_address = 32'h40; m1_write = 1'b1; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'hF;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL both_first got=%b exp=01", grant); end
      checks++; if (m0_readdata !== 32'h11112222) begin failures++; $display("FAIL both_m0_rdata got=%h exp=11112222", m0_readdata); end
      checks++; if (m1_waitrequest !== 1'b1) begin failures++; $display("FAIL both_m1_wait got=%b exp=1", m1_waitrequest); end
      tick();
      m0_read = 1'b0;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL both_idle got=%b exp=00", grant); end
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'b10) begin failures++; $display("FAIL both_second got=%b exp=10", grant); end
      checks++; if (s_write !== 1'b1 || s_address !== 32'h40 || s_writedata !== 32'hDEADBEEF) begin
         failures++; $display("FAIL both_s_fwd got=%b/%h/%h exp=1/00000040/deadbeef", s_write, s_address, s_writedata); end
      checks++; if (m0_waitrequest !== 1'b1) begin failures++; $display("FAIL both_m0_wait got=%b exp=1", m0_waitrequest); end
      tick();
      m1_write = 1'b0;
      m0_address = 32'h40; m0_read = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL both_rb_grant got=%b exp=01", grant); end
      checks++; if (m0_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL both_readback got=%h exp=deadbeef", m0_readdata); end
      tick();
      m0_read = 1'b0;
   endtask

   task automatic test_alternation();
      int n0 = 0;
      int n1 = 0;
      logic [1:0] exp;
      do_reset();
      m0_address = 32'h04; m0_read = 1'b1;
      m1_address = 32'h08; m1_read = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         exp = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b01 : 2'b10);
         checks++; if (grant !== exp) begin failures++; $display("FAIL alt_grant[%0d] got=%b exp=%b", i, grant, exp); end
         if (grant == 2'b01) n0++;
         if (grant == 2'b10) begin
            n1++;
            checks++; if (m1_readdata !== 32'h11112222) begin failures++; $display("FAIL alt_m1_rdata[%0d] got=%h exp=11112222", i, m1_readdata); end
         end
         tick();
      end
      m0_read = 1'b0; m1_read = 1'b0;
      checks++; if (n0 != 4 || n1 != 4) begin failures++; $display("FAIL alt_counts got=%0d/%0d exp=4/4", n0, n1); end
   endtask

   task automatic test_waitstates();
      do_reset();
      m1_address = 32'h10; m1_write = 1'b1; m1_writedata = 32'hCAFEF00D; m1_byteenable = 4'h3;
      s_waitrequest = 1'b1;
      @(negedge clk);
      tick();
      m0_address = 32'h04; m0_read = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) s_waitrequest = 1'b0;
         @(negedge clk);
         checks++; if (grant !== 2'b10 || s_write !== 1'b1 || s_address !== 32'h10 ||
                       s_writedata !== 32'hCAFEF00D || s_byteenable !== 4'h3) begin
            failures++; $display("FAIL ws_hold[%0d] got=%b/%b/%h/%h/%h exp=10/1/00000010/cafef00d/3",
                                 k, grant, s_write, s_address, s_writedata, s_byteenable); end
         checks++; if (m0_waitrequest !== 1'b1) begin failures++; $display("FAIL ws_m0_wait[%0d] got=%b exp=1", k, m0_waitrequest); end
         checks++; if (m1_waitrequest !== (k < 3)) begin failures++; $display("FAIL ws_m1_wait[%0d] got=%b exp=%b", k, m1_waitrequest, (k < 3)); end
         tick();
      end
      m1_write = 1'b0;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL ws_idle got=%b exp=00", grant); end
      checks++; if (mem[4] !== 32'h0000F00D) begin failures++; $display("FAIL ws_ram got=%h exp=0000f00d", mem[4]); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL ws_err got=%b exp=0", err); end
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL ws_m0_next got=%b exp=01", grant); end
      tick();
      m0_read = 1'b0;
   endtask

   task automatic test_watchdog();
      do_reset();
      s_waitrequest = 1'b1;
      m0_address = 32'h04; m0_read = 1'b1;
      @(negedge clk);
      tick();
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checks++; if (err !== (k >= 5)) begin failures++; $display("FAIL wd_err[stall %0d] got=%b exp=%b", k, err, (k >= 5)); end
         checks++; if (grant !== 2'b01) begin failures++; $display("FAIL wd_grant[stall %0d] got=%b exp=01", k, grant); end
         tick();
      end
      s_waitrequest = 1'b0;
      @(negedge clk);
      checks++; if (m0_waitrequest !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL wd_complete got=%b/%b exp=0/1", m0_waitrequest, err); end
      tick();
      m0_read = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (err !== 1'b1 || grant !== 2'b00) begin failures++; $display("FAIL wd_sticky[%0d] got=%b/%b exp=1/00", k, err, grant); end
         tick();
      end
   endtask

   task automatic test_reset_mid_grant();
      m1_address = 32'h08; m1_read = 1'b1;
      s_waitrequest = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'b10) begin failures++; $display("FAIL rmg_pre got=%b exp=10", grant); end
      reset = 1'b1;
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'b00 || s_read !== 1'b0 || s_write !== 1'b0) begin
         failures++; $display("FAIL rmg_after got=%b/%b/%b exp=00/0/0", grant, s_read, s_write); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rmg_err got=%b exp=0", err); end
      reset = 1'b0;
      s_waitrequest = 1'b0;
      m0_address = 32'h04; m0_read = 1'b1;
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rmg_tie got=%b exp=01", grant); end
      tick();
      m0_read = 1'b0; m1_read = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_single_read();
      test_both_request();
      test_alternation();
      test_waitstates();
      test_watchdog();
      test_reset_mid_grant();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/avalon_mem_arbiter.md
Name: avalon_mem_arbiter

Overview:
- Shares the single Avalon-MM RAM slave between two Avalon-MM masters: m0 (instruction fetch) and m1 (data load/store).
- Sits between the CPU bus ports and the RAM, replacing the direct CPU-to-RAM hookup.
- Arbitration is round-robin, one whole transaction per grant, with an optional stall watchdog.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byteenable width is DATA_W/8
- TIMEOUT, 1023, consecutive granted waitrequest cycles before err sets; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  master 0 address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_byteenable  in  DATA_W/8  master 0 byte enables
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m1_*  (same seven signals and directions as m0_*)  master 1
- s_address  out  ADDR_W  to RAM
- s_read  out  1  to RAM
- s_write  out  1  to RAM
- s_writedata  out  DATA_W  to RAM
- s_byteenable  out  DATA_W/8  to RAM
- s_waitrequest  in  1  from RAM
- s_readdata  in  DATA_W  from RAM
- grant  out  2  one-hot current owner; 00 when idle
- err  out  1  sticky watchdog flag

Behaviour:
- Request definitions: req0 = m0_read|m0_write; req1 = m1_read|m1_write.

State machine: IDLE, GRANT0, GRANT1.
- On reset (sampled at a clk edge): state=IDLE, last=1 (so m0 wins the first tie), err=0, watchdog counter=0.

IDLE:
- All s_* outputs are 0; grant=00; both m*_waitrequest=1; both m*_readdata=0.
- Next state: req0 & !req1 -> GRANT0; req1 & !req0 -> GRANT1.
- req0 & req1 -> GRANT1 if last==0, else GRANT0.
- No request -> stay IDLE.

GRANTx:
- s_address, s_read, s_write, s_writedata, s_byteenable are combinationally driven from master x.
- mx_waitrequest = s_waitrequest and mx_readdata = s_readdata, both combinationally.
- The other master: waitrequest=1, readdata=0.
- grant is one-hot on bit x.

Completion:
- A transaction completes in the cycle where (s_read|s_write) & !s_waitrequest.
- On completion: next state=IDLE and last=x.
- The arbiter never holds a grant across two transactions, so there are no back-to-back grants to the same master.

Protocol violation:
- If master x drops req while in GRANTx, return to IDLE next cycle, set last=x, leave err unchanged.

Latency and throughput:
- A request seen in IDLE at edge N is presented to the slave during cycle N+1.
- With s_waitrequest=0 the transaction completes in that same cycle: 2 cycles from request to completion.
- Minimum 2 cycles per transaction, so peak throughput is 50% of cycles.

Watchdog:
- The counter increments on each GRANTx cycle with s_waitrequest=1; it clears on completion or in IDLE.
- When the counter reaches TIMEOUT, err<=1 and holds until reset.
- The transaction is not aborted. The counter saturates.

Other rules:
- Simultaneous m_read & m_write from one master is forwarded unchanged; no checking.
- Reset mid-transaction: s_read and s_write are 0 from the cycle after the reset edge. The slave may lose the in-flight write.
- Address and data are forwarded unmodified; no width conversion.

Test Plan:
- Single m0 read of address 0x04, RAM preloaded with 0x24020010 -> grant=01 for 1 cycle after IDLE, m0_readdata=0x24020010, 2-cycle latency, m1_waitrequest held at 1.
- m0 and m1 both request from reset (m0 read 0x08, m1 write 0xDEADBEEF to 0x40) -> m0 served first, then m1; readback of 0x40 returns 0xDEADBEEF.
- Both masters request continuously for 8 transactions -> grant alternates 01,10,01,...; each master gets 4 transactions; IDLE between each.
- RAM asserts waitrequest 3 cycles on an m1 write -> s_* signals held stable for 4 cycles, m0 stalled throughout, completion on the 4th cycle.
- TIMEOUT=4, RAM holds waitrequest for 10 cycles -> err rises on the 4th stalled cycle and stays 1 after completion until reset.
- Reset asserted during GRANT1 -> next cycle: grant=00, s_read=s_write=0, err=0; the next simultaneous request is granted to m0.
